// File: rtl/id_ex_imm_ctrl.sv
// ============================================================================
//  Module   : id_ex_imm_ctrl
//  Purpose  : ID-stage immediate-path controller. It selects sign or zero
//             extension, captures the ID/EX immediate register and sequences
//             load-use stalls, bubbles and flushes.
//  Options  : ID_CTRL_STATS_EN adds a saturating load-use stall counter port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_imm_ctrl #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_id_instr,
    input  logic              if_id_valid,
    input  logic [DATA_W-1:0] ext_o32,
    input  logic              flush,
    input  logic              stall_in,
    output logic              ext_ctr,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rt,
    output logic              ex_mem_read,
    output logic              ex_valid,
    output logic              if_id_stall
`ifdef ID_CTRL_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // Register fields sit directly above the raw immediate in the encoding.
    localparam int c_RT_LSB = IMM_W;
    localparam int c_RS_LSB = IMM_W + 5;
    localparam int c_OP_LSB = IMM_W + 10;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [1:0] c_RUN       = 2'd0;
    localparam logic [1:0] c_LU_BUBBLE = 2'd1;
    localparam logic [1:0] c_HOLD      = 2'd2;

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic              w_rt_src;
    logic              w_lu;

    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic              ex_valid_q, ex_valid_d;
    logic [1:0]        state_q, state_d;

    assign w_op = if_id_instr[c_OP_LSB +: 6];
    assign w_rs = if_id_instr[c_RS_LSB +: 5];
    assign w_rt = if_id_instr[c_RT_LSB +: 5];
    assign w_rd = if_id_instr[15:11];

    always_comb begin
        ext_ctr = 1'b0;
        case (w_op)
            6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0B, 6'h23, 6'h2B: ext_ctr = 1'b1;
            default:                    ext_ctr = 1'b0;
        endcase
    end

    assign w_rt_src = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                      (w_op == c_OP_BNE)   || (w_op == c_OP_SW);

    assign w_lu = ex_valid_q && ex_mem_read_q && if_id_valid &&
                  (ex_rt_q != 5'd0) &&
                  ((ex_rt_q == w_rs) || (w_rt_src && (ex_rt_q == w_rt)));

    assign if_id_stall = ~rst & ~flush & (stall_in | w_lu);

    always_comb begin
        ex_imm_d      = ex_imm_q;
        ex_rt_d       = ex_rt_q;
        ex_mem_read_d = ex_mem_read_q;
        ex_valid_d    = ex_valid_q;
        state_d       = c_RUN;
        if (flush || (!stall_in && w_lu)) begin
            ex_imm_d      = '0;
            ex_rt_d       = 5'd0;
            ex_mem_read_d = 1'b0;
            ex_valid_d    = 1'b0;
            state_d       = flush ? c_RUN : c_LU_BUBBLE;
        end else if (stall_in) begin
            state_d = c_HOLD;
        end else begin
            ex_imm_d      = ext_o32;
            ex_rt_d       = (w_op == c_OP_RTYPE) ? w_rd : w_rt;
            ex_mem_read_d = (w_op == c_OP_LW) && if_id_valid;
            ex_valid_d    = if_id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_imm_q      <= '0;
            ex_rt_q       <= 5'd0;
            ex_mem_read_q <= 1'b0;
            ex_valid_q    <= 1'b0;
            state_q       <= c_RUN;
        end else begin
            ex_imm_q      <= ex_imm_d;
            ex_rt_q       <= ex_rt_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_valid_q    <= ex_valid_d;
            state_q       <= state_d;
        end
    end

    assign ex_imm      = ex_imm_q;
    assign ex_rt       = ex_rt_q;
    assign ex_mem_read = ex_mem_read_q;
    assign ex_valid    = ex_valid_q;

`ifdef ID_CTRL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_d == c_LU_BUBBLE) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // Registered state is kept for debug visibility only.
    logic w_unused_bits;
    assign w_unused_bits = ^{state_q, if_id_instr[10:0]};

endmodule

`default_nettype wire

// File: tb/tb_id_ex_imm_ctrl.sv
// ============================================================================
//  Module   : tb_id_ex_imm_ctrl
//  Purpose  : Directed, self-checking bench for id_ex_imm_ctrl with a
//             behavioural ID/EX model and literal spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_imm_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] ext_o32;
    logic        flush;
    logic        stall_in;
    logic        ext_ctr;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rt;
    logic        ex_mem_read;
    logic        ex_valid;
    logic        if_id_stall;
`ifdef ID_CTRL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model of the ID/EX register contents.
    logic [31:0] m_imm;
    logic [4:0]  m_rt;
    logic        m_mr;
    logic        m_valid;
    int          m_cnt;

    id_ex_imm_ctrl #(.IMM_W(16), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .ext_o32     (ext_o32),
        .flush       (flush),
        .stall_in    (stall_in),
        .ext_ctr     (ext_ctr),
        .ex_imm      (ex_imm),
        .ex_rt       (ex_rt),
        .ex_mem_read (ex_mem_read),
        .ex_valid    (ex_valid),
        .if_id_stall (if_id_stall)
`ifdef ID_CTRL_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic f_sext(input logic [5:0] op);
        return (op == 6'h04 || op == 6'h05 || op == 6'h08 || op == 6'h09 ||
                op == 6'h0A || op == 6'h0B || op == 6'h23 || op == 6'h2B);
    endfunction

    function automatic logic [31:0] f_ext(input logic [31:0] instr);
        logic [15:0] imm;
        imm = instr[15:0];
        return f_sext(instr[31:26]) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

    function automatic logic f_hazard(input logic [31:0] instr, input logic v);
        logic [5:0] op;
        logic       uses_rt;
        op      = instr[31:26];
        uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        if (!(m_valid && m_mr && v) || m_rt == 5'd0) return 1'b0;
        return (m_rt == instr[25:21]) || (uses_rt && m_rt == instr[20:16]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_imm = 0; m_rt = 0; m_mr = 0; m_valid = 0; m_cnt = 0;
        end else if (flush) begin
            m_imm = 0; m_rt = 0; m_mr = 0; m_valid = 0;
        end else if (stall_in) begin
            // hold
        end else if (f_hazard(if_id_instr, if_id_valid)) begin
            m_imm = 0; m_rt = 0; m_mr = 0; m_valid = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_imm   = f_ext(if_id_instr);
            m_rt    = (if_id_instr[31:26] == 6'h00) ? if_id_instr[15:11] : if_id_instr[20:16];
            m_mr    = (if_id_instr[31:26] == 6'h23) && if_id_valid;
            m_valid = if_id_valid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ext_ctr", {31'd0, ext_ctr}, {31'd0, f_sext(if_id_instr[31:26])});
            chk("if_id_stall", {31'd0, if_id_stall},
                {31'd0, ~rst & ~flush & (stall_in | f_hazard(if_id_instr, if_id_valid))});
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rt", {27'd0, ex_rt}, {27'd0, m_rt});
            chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
`ifdef ID_CTRL_STATS_EN
            chk("stall_cnt", {16'd0, stall_cnt}, m_cnt[31:0]);
`endif
        end
    end

    // Apply one cycle of inputs; returns mid-cycle with them settled.
    task automatic apply(input logic [31:0] instr, input logic v, input logic fl,
                         input logic st, input logic r);
        @(posedge clk);
        #1;
        if_id_instr = instr;
        if_id_valid = v;
        ext_o32     = f_ext(instr);
        flush       = fl;
        stall_in    = st;
        rst         = r;
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] ORI   = 32'h3402_8000; // ori  $2,$0,0x8000
    localparam logic [31:0] ADDI  = 32'h2002_FFFF; // addi $2,$0,-1
    localparam logic [31:0] LW3   = 32'h8C23_0000; // lw   $3,0($1)
    localparam logic [31:0] ADD   = 32'h0065_2020; // add  $4,$3,$5
    localparam logic [31:0] LW0   = 32'h8C20_0000; // lw   $0,0($1)
    localparam logic [31:0] ADD0  = 32'h0000_2020; // add  $4,$0,$0
    localparam logic [31:0] SW3   = 32'hACE3_0000; // sw   $3,0($7)
    localparam logic [31:0] ADDI3 = 32'h20C3_0001; // addi $3,$6,1
    localparam logic [31:0] NOP   = 32'h0000_0000;

    initial begin
        logic [31:0] held_imm;
        logic [5:0]  ops [0:7];
        logic        ctr_exp [0:7];
        ops     = '{6'h0C, 6'h0D, 6'h0F, 6'h08, 6'h0B, 6'h2B, 6'h3F, 6'h02};
        ctr_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; if_id_instr = NOP; if_id_valid = 0; ext_o32 = 0; flush = 0; stall_in = 0;
        apply(NOP, 0, 0, 0, 1);
        apply(NOP, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_imm", ex_imm, 32'd0);

        // ori: zero extension
        apply(ORI, 1, 0, 0, 0);
        chk("ori_ctr", {31'd0, ext_ctr}, 32'd0);
        apply(ADDI, 1, 0, 0, 0);
        chk("ori_imm", ex_imm, 32'h0000_8000);
        chk("ori_rt", {27'd0, ex_rt}, 32'd2);
        chk("ori_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_ctr", {31'd0, ext_ctr}, 32'd1);
        apply(NOP, 1, 0, 0, 0);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFF);

        // lw $3 then add using $3: one bubble
        apply(LW3, 1, 0, 0, 0);
        apply(ADD, 1, 0, 0, 0);
        chk("lu_stall", {31'd0, if_id_stall}, 32'd1);
        apply(ADD, 1, 0, 0, 0);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_release", {31'd0, if_id_stall}, 32'd0);
        apply(NOP, 1, 0, 0, 0);
        chk("lu_add_rt", {27'd0, ex_rt}, 32'd4);
`ifdef ID_CTRL_STATS_EN
        chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
`endif

        // lw $0: never a hazard
        apply(LW0, 1, 0, 0, 0);
        apply(ADD0, 1, 0, 0, 0);
        chk("lw0_nostall", {31'd0, if_id_stall}, 32'd0);

        // sw uses rt as a source
        apply(LW3, 1, 0, 0, 0);
        apply(SW3, 1, 0, 0, 0);
        chk("sw_stall", {31'd0, if_id_stall}, 32'd1);
        apply(SW3, 1, 0, 0, 0);

        // addi writes rt: no hazard
        apply(LW3, 1, 0, 0, 0);
        apply(ADDI3, 1, 0, 0, 0);
        chk("addi_rt_nostall", {31'd0, if_id_stall}, 32'd0);

        // flush beats hazard
        apply(LW3, 1, 0, 0, 0);
        apply(ADD, 1, 1, 0, 0);
        chk("flush_nostall", {31'd0, if_id_stall}, 32'd0);
        apply(NOP, 1, 0, 0, 0);
        chk("flush_bubble", {31'd0, ex_valid}, 32'd0);

        // downstream stall for three cycles holds ID/EX
        apply(ORI, 1, 0, 0, 0);
        apply(ADDI, 1, 0, 1, 0);
        held_imm = ex_imm;
        chk("hold_stall0", {31'd0, if_id_stall}, 32'd1);
        apply(ADDI, 1, 0, 1, 0);
        chk("hold_stall1", {31'd0, if_id_stall}, 32'd1);
        chk("hold_imm1", ex_imm, held_imm);
        apply(ADDI, 1, 0, 1, 0);
        chk("hold_stall2", {31'd0, if_id_stall}, 32'd1);
        chk("hold_imm2", ex_imm, 32'h0000_8000);
        apply(ADDI, 1, 0, 0, 0);

        // stall_in together with a hazard: hold, then the bubble
        apply(LW3, 1, 0, 0, 0);
        apply(ADD, 1, 0, 1, 0);
        apply(ADD, 1, 0, 0, 0);
        chk("st_lu_memread", {31'd0, ex_mem_read}, 32'd1);
        apply(ADD, 1, 0, 0, 0);

        // reset during the load-use bubble
        apply(LW3, 1, 0, 0, 0);
        apply(ADD, 1, 0, 0, 0);
        apply(ADD, 1, 0, 0, 1);
        chk("rst_nostall", {31'd0, if_id_stall}, 32'd0);
        apply(ADD, 1, 0, 0, 0);
        chk("rst_valid0", {31'd0, ex_valid}, 32'd0);
        chk("rst_rt0", {27'd0, ex_rt}, 32'd0);
        apply(NOP, 1, 0, 0, 0);
        chk("rst_resume_rt", {27'd0, ex_rt}, 32'd4);

        // invalid IF/ID: no hazard, bubble propagates
        apply(LW3, 1, 0, 0, 0);
        apply(ADD, 0, 0, 0, 0);
        chk("inv_nostall", {31'd0, if_id_stall}, 32'd0);
        apply(NOP, 1, 0, 0, 0);
        chk("inv_valid0", {31'd0, ex_valid}, 32'd0);

        // extension control across opcode table
        for (int i = 0; i < 8; i++) begin
            apply({ops[i], 26'h0012345}, 1, 0, 0, 0);
            chk("op_table_ctr", {31'd0, ext_ctr}, {31'd0, ctr_exp[i]});
        end
        apply(NOP, 0, 0, 0, 0);
        apply(NOP, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_imm_ctrl.md
# id_ex_imm_ctrl

ID-stage controller for the immediate path of the pipelined CPU. It decodes the IF/ID instruction opcode to drive the `ctr` input of the sign extender, and captures the extended immediate into the ID/EX pipeline register. It also detects load-use hazards against the instruction currently in ID/EX and sequences stalls, bubbles and flushes for that register. It sits between the IF/ID register and the EX stage, next to the register file.

## Interface
Parameters:
- `IMM_W`, 16: raw immediate width (instruction bits [15:0]).
- `DATA_W`, 32: extended immediate width.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_id_instr` input 32: instruction in IF/ID.
- `if_id_valid` input 1: IF/ID holds a real instruction.
- `ext_o32` input DATA_W: result returned by the sign extender for `if_id_instr[15:0]`.
- `flush` input 1: taken branch/jump resolved in EX; kill the ID instruction.
- `stall_in` input 1: downstream (MEM) stall; freeze ID/EX.
- `ext_ctr` output 1: combinational `ctr` to the sign extender (1 = sign-extend, 0 = zero-extend).
- `ex_imm` output DATA_W: registered ID/EX immediate.
- `ex_rt` output 5: registered destination/rt field.
- `ex_mem_read` output 1: registered "ID/EX is a load".
- `ex_valid` output 1: ID/EX holds a real instruction.
- `if_id_stall` output 1: combinational; hold PC and IF/ID this cycle.
- `stall_cnt` output 16: load-use stall counter (present only with the stats macro).

## Operation
- Opcode `op = if_id_instr[31:26]`.
- `ext_ctr = 0` for `op` 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui, and 0x00 R-type.
- `ext_ctr = 1` for 0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x23 lw, 0x2B sw.
- `ext_ctr = 0` for every other opcode.
- Source use:
  - rs = `[25:21]` is always used.
  - rt = `[20:16]` is used as a source only for R-type, beq, bne and sw.
- Load-use hazard `lu` is asserted when all of the following hold:
  - `ex_valid`, `ex_mem_read` and `if_id_valid` are 1;
  - `ex_rt != 0`;
  - `ex_rt == rs`, or `ex_rt == rt` with rt used as a source.
- Per-cycle action, in priority order:
  1. `rst`: all registers cleared.
  2. `flush`: load a bubble.
  3. `stall_in`: hold ID/EX unchanged.
  4. `lu`: load a bubble.
  5. Otherwise: load a new instruction.
- Bubble: `ex_valid = 0`, `ex_mem_read = 0`, `ex_rt = 0`, `ex_imm = 0`.
- Load new instruction:
  - `ex_imm <= ext_o32`.
  - `ex_rt <= instr[20:16]` for I-type; `instr[15:11]` for R-type.
  - `ex_mem_read <= (op == 0x23) & if_id_valid`.
  - `ex_valid <= if_id_valid`.
- `if_id_stall = ~rst & ~flush & (stall_in | lu)`.
- Controller state is {RUN, LU_BUBBLE, HOLD}, registered.
  - Transitions are decided by the priority above: `lu` → LU_BUBBLE, `stall_in` → HOLD, otherwise RUN.
  - The state is used only to count stalls and for debug.
  - LU_BUBBLE lasts exactly one cycle unless `stall_in` intervenes.

## Timing
- Reset values: `ex_imm = 0`, `ex_rt = 0`, `ex_mem_read = 0`, `ex_valid = 0`, `stall_cnt = 0`, state = RUN.
- `ext_ctr` and `if_id_stall` are combinational from current inputs and registers (zero latency).
- ID → EX latency: 1 cycle. An instruction in IF/ID at edge N appears on the `ex_*` outputs after edge N.
- A load-use hazard costs exactly 1 bubble cycle. Next cycle `ex_mem_read = 0`, so `lu` deasserts and the held instruction advances.
- `flush` together with `lu` or `stall_in`: flush wins. A bubble is loaded and `if_id_stall = 0`.
- `stall_in` together with `lu`: hold. `lu` is re-evaluated every cycle until the load leaves ID/EX.
- `if_id_valid = 0`: no hazard; a bubble propagates (`ex_valid = 0`).
- `rst` asserted mid-stall: state returns to RUN, outputs take reset values, and `if_id_stall = 0` in the same cycle.

## Configuration
- Macro `ID_CTRL_STATS_EN`.
- Defined:
  - `stall_cnt` is present.
  - It increments by 1 on every edge where the action is a load-use bubble.
  - It saturates at 0xFFFF and clears on `rst`.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- ori, instr 0x3402_8000 → `ext_ctr = 0`; next cycle `ex_imm = 0x0000_8000`, `ex_rt = 2`, `ex_valid = 1`.
- addi, instr 0x2002_FFFF → `ext_ctr = 1`; next cycle `ex_imm = 0xFFFF_FFFF`.
- `lw $3,0($1)` followed by `add $4,$3,$5`:
  - Cycle 2: `if_id_stall = 1`.
  - Then `ex_valid = 0` for one cycle.
  - Then the add loads into ID/EX.
  - `stall_cnt = 1` when stats are enabled.
- `lw $0,…` followed by a use of `$0` → no stall. `lw $3` followed by `sw $3` as rt source → 1 stall. `lw $3` followed by `addi $3,$6,1` (rt is destination) → no stall.
- Hazard cycle with `flush = 1` → `if_id_stall = 0` and a bubble is loaded. `stall_in = 1` for 3 cycles → `ex_*` held constant and `if_id_stall = 1` throughout.
- `rst` pulsed during LU_BUBBLE → next cycle all outputs are 0 and normal loading resumes.
